snes_pad_poller: RTL

Console-side initiator for the SNES controller serial port. It generates the LATCH pulse and 16 CLK pulses, samples the pad's serial data, and publishes the 16-bit button word to the rest of the design. The block sits in the same clock domain as the controller-snoop receiver and uses the same bit ordering, so command words are directly comparable. It lets the design poll a pad on its own when no console is driving the port, for example in the test fixture or in stand-alone IGR.

---
 rtl/snes_ctrl_pkg.sv | 28 ++
 rtl/snes_pad_poller_if.sv | 21 ++
 rtl/sync2.sv | 31 +++
 rtl/snes_pad_poller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/snes_ctrl_pkg.sv
// rtl/snes_ctrl_pkg.sv - shared SNES controller-port constants, IGR command words and poller FSM states.
package snes_ctrl_pkg;

  localparam int NUM_BITS = 16;

  localparam logic IDLE_LATCH = 1'b0;
  localparam logic IDLE_CLK   = 1'b1;

  localparam logic [NUM_BITS-1:0] PDATA_RST = 16'hFFFF;

  // Raw serial words (first bit in bit 15), directly comparable with the snoop receiver
  localparam logic [NUM_BITS-1:0] IGR_BIOS = 16'h5fcf;
  localparam logic [NUM_BITS-1:0] IGR_NTSC = 16'hdf4f;
  localparam logic [NUM_BITS-1:0] IGR_PAL  = 16'h9fcf;
  localparam logic [NUM_BITS-1:0] IGR_SRST = 16'hcfcf;
  localparam logic [NUM_BITS-1:0] IGR_DRST = 16'hdf8f;
  localparam logic [NUM_BITS-1:0] IGR_LRST = 16'hd7cf;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/snes_pad_poller_if.sv
// rtl/snes_pad_poller_if.sv - host-side request/result bus of the SNES pad poller.
interface snes_pad_poller_if;
  import snes_ctrl_pkg::*;

  logic                START_i;
  logic                AUTO_EN_i;
  logic                BUSY_o;
  logic [NUM_BITS-1:0] PDATA_o;
  logic                PDATA_VALID_o;

  modport master (
    output START_i, AUTO_EN_i,
    input  BUSY_o, PDATA_o, PDATA_VALID_o
  );

  modport slave (
    input  START_i, AUTO_EN_i,
    output BUSY_o, PDATA_o, PDATA_VALID_o
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with a configurable reset level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK_i,
  input  logic NRST_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/snes_pad_poller.sv
// rtl/snes_pad_poller.sv - console-side SNES pad poller: LATCH pulse, 16 CLK pulses, serial capture.
module snes_pad_poller
  import snes_ctrl_pkg::*;
#(
  parameter int HALF_CYC  = 64,
  parameter int LATCH_CYC = 256,
  parameter int POLL_CYC  = 357955
) (
  input  logic               CLK_i,
  input  logic               NRST_i,
  snes_pad_poller_if.slave   host,
  input  logic               CTRL_SDATA_i,
  output logic               CTRL_LATCH_o,
  output logic               CTRL_CLK_o
);

  localparam int PH_MAX = (HALF_CYC > LATCH_CYC) ? HALF_CYC : LATCH_CYC;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int TMR_W  = $clog2(POLL_CYC);

  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYC - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYC - 1);

  logic sdata_sync;

  sync2 #(.RST_VAL(1'b1)) u_sync2 (
    .CLK_i  (CLK_i),
    .NRST_i (NRST_i),
    .d_i    (CTRL_SDATA_i),
    .q_o    (sdata_sync)
  );

  state_e              state_q, state_d;
  logic [PH_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [3:0]          idx_q, idx_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] pdata_q, pdata_d;
  logic                latch_q, latch_d;
  logic                clk_q, clk_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                tmr_wrap;
  logic                trigger;

  always_comb begin
    tmr_wrap = host.AUTO_EN_i && (tmr_q == TMR_LAST);
    trigger  = host.START_i || tmr_wrap;

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    latch_d = latch_q;
    clk_d   = clk_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    // Timer keeps running during a poll; a wrap while busy is simply dropped
    if (!host.AUTO_EN_i || tmr_wrap) tmr_d = '0;
    else                             tmr_d = tmr_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_LATCH;
          latch_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          shift_d = PDATA_RST;
        end
      end
      ST_LATCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_GAP;
          latch_d = IDLE_LATCH;
          cnt_d   = '0;
          idx_d   = 4'(NUM_BITS - 1);
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          state_d = ST_LOW;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          shift_d[idx_q] = sdata_sync;
          state_d = ST_HIGH;
          clk_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd0) begin
            state_d = ST_DONE;
            pdata_d = shift_q;
            valid_d = 1'b1;
          end else begin
            state_d = ST_LOW;
            idx_d   = idx_q - 1'b1;
            clk_d   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = IDLE_LATCH;
        clk_d   = IDLE_CLK;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= PDATA_RST;
      pdata_q <= PDATA_RST;
      latch_q <= IDLE_LATCH;
      clk_q   <= IDLE_CLK;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      latch_q <= latch_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign CTRL_LATCH_o       = latch_q;
  assign CTRL_CLK_o         = clk_q;
  assign host.BUSY_o        = busy_q;
  assign host.PDATA_o       = pdata_q;
  assign host.PDATA_VALID_o = valid_q;

endmodule
